// File: rtl/mux_sel_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : mux_sel_pipe_if
// Brief   : Handshake bundle for mux_sel_pipe: upstream select beat in,
//           downstream registered data beat out.
// Revision: 1.0 - initial release
// ============================================================================
interface mux_sel_pipe_if #(
    parameter int WIDTH  = 3,
    parameter int NUM_IN = 5,
    parameter int SEL_W  = 3
);
    logic                    s_valid;
    logic                    s_ready;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic                    m_valid;
    logic                    m_ready;
    logic [WIDTH-1:0]        m_data;
    logic                    m_miss;

    // master drives beats into the selector and consumes its output
    modport master (
        output s_valid, sel, in_bus, m_ready,
        input  s_ready, m_valid, m_data, m_miss
    );

    modport slave (
        input  s_valid, sel, in_bus, m_ready,
        output s_ready, m_valid, m_data, m_miss
    );
endinterface
`default_nettype wire

// File: rtl/mux_sel_pipe.sv
`default_nettype none
// ============================================================================
// Module  : mux_sel_pipe
// Brief   : Registered N-input selector with valid/ready handshake; out-of-range
//           selects are resolved by MISS_MODE, flagged per beat and counted.
// Revision: 1.0 - initial release
// ============================================================================
module mux_sel_pipe #(
    parameter int WIDTH     = 3,
    parameter int NUM_IN    = 5,
    parameter int SEL_W     = 3,
    parameter int MISS_MODE = 0,
    parameter int CNT_W     = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    mux_sel_pipe_if.slave         bus,
    input  wire logic             err_clr,
    output logic                  err,
    output logic [CNT_W-1:0]      miss_cnt
);

    generate
        if (NUM_IN < 1 || NUM_IN > (2 ** SEL_W)) begin : g_cfg_check
            $error("mux_sel_pipe: NUM_IN must lie in 1..2**SEL_W");
        end
    endgenerate

    // one extra bit so NUM_IN == 2**SEL_W is representable
    localparam logic [SEL_W:0] c_num_in = NUM_IN[SEL_W:0];

    logic [WIDTH-1:0] w_in [NUM_IN];
    logic [WIDTH-1:0] w_pick;
    logic [WIDTH-1:0] w_next_data;
    logic             w_in_range;
    logic             w_accept;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_miss;
    logic [WIDTH-1:0] r_last;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    genvar k;
    generate
        for (k = 0; k < NUM_IN; k++) begin : g_unpack
            assign w_in[k] = bus.in_bus[k*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        w_pick = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (bus.sel == i[SEL_W-1:0]) begin
                w_pick = w_in[i];
            end
        end
    end

    assign w_in_range  = ({1'b0, bus.sel} < c_num_in);
    assign w_next_data = w_in_range        ? w_pick :
                         (MISS_MODE != 0)  ? '0     : r_last;
    assign bus.s_ready = !r_valid || bus.m_ready;
    assign w_accept    = bus.s_valid && bus.s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_miss  <= 1'b0;
            r_last  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_data  <= w_next_data;
                r_miss  <= !w_in_range;
                if (w_in_range) begin
                    r_last <= w_pick;
                end
            end else if (bus.m_ready) begin
                r_valid <= 1'b0;
            end

            // a clear in the same cycle as a miss wins over the increment
            if (err_clr) begin
                r_err <= 1'b0;
                r_cnt <= '0;
            end else if (w_accept && !w_in_range) begin
                r_err <= 1'b1;
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.m_valid = r_valid;
    assign bus.m_data  = r_data;
    assign bus.m_miss  = r_miss;
    assign err         = r_err;
    assign miss_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_sel_pipe
// Brief   : Three selector configurations on shared stimulus, scoreboard-checked
//           against a per-configuration behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux_sel_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       s_valid = 1'b0;
    logic       m_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] sel = 3'd0;
    logic [2:0] inval [8];
    logic [23:0] in_bus;

    always #5 clk = ~clk;

    always_comb begin
        in_bus = '0;
        for (int k = 0; k < 8; k++) in_bus[k*3 +: 3] = inval[k];
    end

    // a: hold-last, 8-bit count; b: zero-on-miss, 2-bit count; c: full decode
    mux_sel_pipe_if #(.WIDTH(3), .NUM_IN(5), .SEL_W(3)) if_a ();
    mux_sel_pipe_if #(.WIDTH(3), .NUM_IN(5), .SEL_W(3)) if_b ();
    mux_sel_pipe_if #(.WIDTH(3), .NUM_IN(8), .SEL_W(3)) if_c ();

    logic       err_a, err_b, err_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;

    assign if_a.s_valid = s_valid; assign if_a.sel = sel; assign if_a.m_ready = m_ready;
    assign if_b.s_valid = s_valid; assign if_b.sel = sel; assign if_b.m_ready = m_ready;
    assign if_c.s_valid = s_valid; assign if_c.sel = sel; assign if_c.m_ready = m_ready;
    assign if_a.in_bus  = in_bus[14:0];
    assign if_b.in_bus  = in_bus[14:0];
    assign if_c.in_bus  = in_bus;

    mux_sel_pipe #(.WIDTH(3), .NUM_IN(5), .SEL_W(3), .MISS_MODE(0), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave), .err_clr(err_clr), .err(err_a), .miss_cnt(cnt_a));
    mux_sel_pipe #(.WIDTH(3), .NUM_IN(5), .SEL_W(3), .MISS_MODE(1), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave), .err_clr(err_clr), .err(err_b), .miss_cnt(cnt_b));
    mux_sel_pipe #(.WIDTH(3), .NUM_IN(8), .SEL_W(3), .MISS_MODE(0), .CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c.slave), .err_clr(err_clr), .err(err_c), .miss_cnt(cnt_c));

    logic       dv [3], dr [3], dm [3], de [3];
    logic [2:0] dd [3];
    int         dc [3];
    assign dv[0] = if_a.m_valid; assign dr[0] = if_a.s_ready; assign dm[0] = if_a.m_miss;
    assign dv[1] = if_b.m_valid; assign dr[1] = if_b.s_ready; assign dm[1] = if_b.m_miss;
    assign dv[2] = if_c.m_valid; assign dr[2] = if_c.s_ready; assign dm[2] = if_c.m_miss;
    assign dd[0] = if_a.m_data;  assign dd[1] = if_b.m_data;  assign dd[2] = if_c.m_data;
    assign de[0] = err_a;        assign de[1] = err_b;        assign de[2] = err_c;
    assign dc[0] = {24'd0, cnt_a};
    assign dc[1] = {30'd0, cnt_b};
    assign dc[2] = {24'd0, cnt_c};

    // reference model: per configuration, expected beats as data + 256*miss
    int         q [3][$];
    logic [2:0] lg [3];
    bit         me [3];
    int         mc [3];
    int         n_checks = 0;
    int         n_fail = 0;

    function automatic int ni(input int i);   return (i == 2) ? 8 : 5;   endfunction
    function automatic bit zero_miss(input int i); return (i == 1);      endfunction
    function automatic int cmax(input int i); return (i == 1) ? 3 : 255; endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, idx, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            q[i].delete();
            lg[i] = 3'd0;
            me[i] = 1'b0;
            mc[i] = 0;
        end
    endtask

    // applied at the rising edge, with inputs that were stable through it
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit acc;
            bit miss;
            int data;
            acc  = s_valid && (q[i].size() == 0);
            miss = (int'(sel) >= ni(i));
            if (acc) begin
                if (!miss) begin
                    data  = int'(inval[sel]);
                    lg[i] = inval[sel];
                end else begin
                    data = zero_miss(i) ? 0 : int'(lg[i]);
                end
                q[i].push_back(data + (miss ? 256 : 0));
            end
            if (err_clr) begin
                me[i] = 1'b0;
                mc[i] = 0;
            end else if (acc && miss) begin
                me[i] = 1'b1;
                if (mc[i] < cmax(i)) mc[i] = mc[i] + 1;
            end
        end
    endtask

    task automatic step(input bit v, input int s, input bit mr, input bit clr);
        s_valid = v;
        sel     = s[2:0];
        m_ready = mr;
        err_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            chk("rst_m_valid", i, int'(dv[i]), 0);
            chk("rst_m_data", i, int'(dd[i]), 0);
            chk("rst_m_miss", i, int'(dm[i]), 0);
            chk("rst_err", i, int'(de[i]), 0);
            chk("rst_miss_cnt", i, dc[i], 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                chk("s_ready", i, int'(dr[i]), int'(q[i].size() == 0 || m_ready));
                chk("m_valid", i, int'(dv[i]), int'(q[i].size() != 0));
                if (q[i].size() != 0) begin
                    if (dv[i]) begin
                        chk("m_data", i, int'(dd[i]), q[i][0] % 256);
                        chk("m_miss", i, int'(dm[i]), q[i][0] / 256);
                    end
                    if (m_ready) void'(q[i].pop_front());
                end
                chk("err", i, int'(de[i]), int'(me[i]));
                chk("miss_cnt", i, dc[i], mc[i]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_ramp();
        for (int k = 0; k < 8; k++) inval[k] = 3'(k + 3);
    endtask

    task automatic set_rand();
        for (int k = 0; k < 8; k++) inval[k] = 3'($urandom);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) inval[k] = 3'd0;
        #2;
        do_reset();

        // back-to-back in-range beats
        set_ramp();
        for (int s = 0; s < 5; s++) step(1'b1, s, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // in-range then out-of-range with changed inputs
        step(1'b1, 2, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) inval[k] = ~inval[k];
        step(1'b1, 6, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // backpressure hold while inputs toggle
        set_ramp();
        step(1'b1, 1, 1'b0, 1'b0);
        repeat (5) begin
            set_rand();
            step(1'b1, int'($urandom_range(0, 7)), 1'b0, 1'b0);
        end
        set_ramp();
        step(1'b1, 4, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // counter saturation, then clear colliding with a miss
        step(1'b0, 0, 1'b1, 1'b1);
        step(1'b1, 5, 1'b1, 1'b0);
        step(1'b1, 6, 1'b1, 1'b0);
        step(1'b1, 7, 1'b1, 1'b0);
        step(1'b1, 5, 1'b1, 1'b0);
        step(1'b1, 6, 1'b1, 1'b0);
        step(1'b1, 7, 1'b1, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0);

        // asynchronous reset with a stalled beat pending
        set_ramp();
        step(1'b1, 3, 1'b1, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        #2;
        do_reset();
        step(1'b1, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // randomized traffic
        repeat (400) begin
            set_rand();
            step(($urandom % 4) != 0, int'($urandom_range(0, 7)),
                 ($urandom % 3) != 0, ($urandom % 16) == 0);
        end

        // full select sweep
        set_ramp();
        step(1'b0, 0, 1'b1, 1'b1);
        for (int s = 0; s < 8; s++) step(1'b1, s, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
